stv_fifo: RTL and testbench
===========================

# stv_fifo

Parametrised-depth ready/valid FIFO: the next generation of the team's single/double-entry buffer. It generalises storage to DEPTH entries, with optional flow-through when empty and occupancy/status outputs for credit and backpressure logic. It sits between pipeline stages, or at clock-gated block boundaries, where more than two beats of slack are needed.

## Interface
- data_t, logic [7:0]: payload type
- DEPTH, 4: number of storage entries, >= 1, need not be a power of two
- FLOW, 1'b0: 1 = empty FIFO passes din to dout combinationally (zero latency); 0 = registered output, minimum latency 1 cycle
- AFULL, DEPTH-1: almost_full threshold, 0..DEPTH
- CW, $clog2(DEPTH+1): derived count width, not to be overridden
- clk  in  1  clock
- arst  in  1  reset. One clock; reset is asynchronous and active-high.
- clear  in  1  synchronous flush
- din_valid  in  1  initiator valid
- din_ready  out  1  initiator ready
- din  in  data_t  initiator payload
- dout_valid  out  1  target valid
- dout_ready  in  1  target ready
- dout  out  data_t  target payload
- count  out  CW  entries currently stored (excludes bypassed beat)
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AFULL

## Operation
- State: wr_ptr, rd_ptr (each 0..DEPTH-1), count (CW bits), all reset by arst. Storage array is not reset.
- push = din_valid && din_ready; pop = dout_valid && dout_ready.
- din_ready = !full && !clear. There is no combinational path from dout_ready to din_ready. When full, a pop and a push never happen in the same cycle.
- FLOW=0:
  - dout_valid = !empty && !clear.
  - dout = mem[rd_ptr].
- FLOW=1:
  - dout_valid = (!empty || din_valid) && !clear.
  - dout = empty ? din : mem[rd_ptr].
  - Empty, push and pop in the same cycle is a bypass: no write, pointers and count unchanged.
- Write: on push (not bypass), mem[wr_ptr] <= din and wr_ptr advances.
- Read: on pop (not bypass), rd_ptr advances.
- Pointer wrap: DEPTH-1 -> 0 by explicit compare, not by modulo-2^n.
- count_next = count + push_stored - pop_stored. It saturates never: a correct design cannot overflow or underflow.
- clear: next cycle wr_ptr = rd_ptr = count = 0. It overrides any push/pop that cycle, and both handshakes are masked during the clear cycle.
- Status outputs are decoded from the count register. They are glitch-free and change only on clk.

## Timing
- Reset values: din_ready=1, dout_valid=0, count=0, empty=1, full=0, almost_full=(AFULL==0). With FLOW=1, dout_valid follows din_valid combinationally even in reset.
- FLOW=0 latency: a beat pushed in cycle N is presented on dout in cycle N+1.
- FLOW=1 latency: 0 cycles when empty; otherwise presented once all older entries have popped.
- full asserts the cycle after the DEPTH-th stored push. din_ready falls in that same cycle.
- arst mid-operation: asynchronous flush. All state returns to the reset values immediately. Stored data is discarded.
- Protocol assertions under STV_ASSERT_ON, disabled while arst is high:
  - din_valid stable while !din_ready.
  - din stable while !din_ready.
  - Never push when full.
  - Never pop when empty, except on a FLOW bypass.

## Structure
- stv_pkg holds the shared helper function ptr_inc(ptr, DEPTH) with wrap. It is also used by future async/credit FIFOs.
- One sub-module: stv_fifo_ptr (parameter DEPTH). It contains the pointer register with increment, wrap and clear, and is instantiated twice, for write and read.
- DEPTH=1 and FLOW=1 are handled in the same RTL without special-case generate blocks beyond ptr width (width max(1,$clog2(DEPTH))).

## Test plan
- Fill/drain: DEPTH=4, FLOW=0, dout_ready=0. Push 0x11,0x22,0x33,0x44.
  - Required: full=1 and din_ready=0 after the 4th push, count=4, almost_full=1 from count=3.
  - Then dout_ready=1: 0x11..0x44 pop in order and empty=1.
- Steady stream: count=2, then push and pop every cycle for 8 cycles. Required: count stays 2 and order is preserved.
- Bypass: FLOW=1, empty, din_valid=1, din=0xA5, dout_ready=1.
  - Required: dout_valid=1 and dout=0xA5 in the same cycle; count stays 0.
  - Repeat with dout_ready=0: next cycle count=1 and dout=0xA5.
- Wrap: DEPTH=3. Stream 0x00..0x09 with random dout_ready and din_valid. Required: all 10 beats out in order; both pointers wrap 2->0 at least three times.
- Clear: count=3, pulse clear with din_valid=1 and dout_ready=1.
  - Required: no handshake that cycle; next cycle count=0, empty=1, dout_valid=0.
  - Next push is read back first.
- Reset mid-operation: count=2, assert arst between clock edges.
  - Required: outputs reach the reset values immediately.
  - After release, the FIFO behaves as freshly reset (first pushed value is first popped).

Source files
------------

// File: rtl/stv_pkg.sv
// rtl/stv_pkg.sv - shared helpers for the stv FIFO family
//
// Purpose: holds the pointer increment with wrap. The ready/valid FIFO uses it,
// and so do the async and credit FIFOs that follow it.
// Ports: none (package).
package stv_pkg;

  // The wrap uses an explicit compare against depth-1, so DEPTH does not need
  // to be a power of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/stv_fifo_ptr.sv
// rtl/stv_fifo_ptr.sv - wrapping FIFO pointer register
//
// Purpose: one FIFO pointer that can be cleared. It increments on inc and wraps
// from DEPTH-1 to 0. The FIFO instantiates it once for writes and once for reads.
// Ports:
//   clk    in   clock
//   arst   in   asynchronous active-high reset
//   clear  in   synchronous clear to 0, wins over inc
//   inc    in   advance pointer
//   ptr    out  current pointer value, max(1,$clog2(DEPTH)) bits
module stv_fifo_ptr
  import stv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          clear,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= PW'(ptr_inc(32'(ptr), DEPTH));
    end
  end

endmodule

// File: rtl/stv_fifo.sv
// rtl/stv_fifo.sv - parametrised-depth ready/valid FIFO with optional flow-through
//
// Purpose: a FIFO with DEPTH entries that sits between pipeline stages. When
// FLOW=1 and the FIFO is empty, din passes straight to dout. The occupancy and
// status outputs are decoded from the count register only.
// Ports:
//   clk          in   clock
//   arst         in   asynchronous active-high reset
//   clear        in   synchronous flush; also masks both handshakes
//   din_valid    in   initiator valid
//   din_ready    out  initiator ready (!full && !clear)
//   din          in   initiator payload
//   dout_valid   out  target valid
//   dout_ready   in   target ready
//   dout         out  target payload
//   count        out  stored entries (a bypassed beat is not counted)
//   empty        out  count == 0
//   full         out  count == DEPTH
//   almost_full  out  count >= AFULL
module stv_fifo
  import stv_pkg::*;
#(
  parameter type data_t = logic [7:0],
  parameter int  DEPTH  = 4,
  parameter bit  FLOW   = 1'b0,
  parameter int  AFULL  = DEPTH - 1,
  parameter int  CW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          clear,
  input  logic          din_valid,
  output logic          din_ready,
  input  data_t         din,
  output logic          dout_valid,
  input  logic          dout_ready,
  output data_t         dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          almost_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  data_t          mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count_next;
  logic           push;
  logic           pop;
  logic           bypass;
  logic           push_st;
  logic           pop_st;

  // The status outputs come only from the count register. Because of that,
  // din_ready has no combinational path from dout_ready.
  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AFULL));

  assign din_ready  = !full && !clear;
  assign dout_valid = (!empty || (FLOW && din_valid)) && !clear;
  assign dout       = (FLOW && empty) ? din : mem[rd_ptr];

  assign push = din_valid && din_ready;
  assign pop  = dout_valid && dout_ready;

  // When the FIFO is empty in flow-through mode, a beat that is both accepted
  // and consumed never touches storage.
  assign bypass  = FLOW && empty && push && pop;
  assign push_st = push && !bypass;
  assign pop_st  = pop && !bypass;

  always_ff @(posedge clk) begin
    if (push_st) begin
      mem[wr_ptr] <= din;
    end
  end

  stv_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .arst  (arst),
    .clear (clear),
    .inc   (push_st),
    .ptr   (wr_ptr)
  );

  stv_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .arst  (arst),
    .clear (clear),
    .inc   (pop_st),
    .ptr   (rd_ptr)
  );

  always_comb begin
    count_next = count;
    case ({push_st, pop_st})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

`ifdef STV_ASSERT_ON
  a_din_valid_hold: assert property (@(posedge clk) disable iff (arst)
    (din_valid && !din_ready) |=> din_valid);
  a_din_hold: assert property (@(posedge clk) disable iff (arst)
    (din_valid && !din_ready) |=> $stable(din));
  a_no_push_full: assert property (@(posedge clk) disable iff (arst)
    !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (arst)
    !(pop && empty && !bypass));
`endif

endmodule

// File: tb/tb_stv_fifo.sv
// tb/tb_stv_fifo.sv - directed self-checking bench for stv_fifo
//
// Purpose: uses three instances: a DEPTH=4 registered FIFO, a DEPTH=4
// flow-through FIFO and a DEPTH=3 registered FIFO. Inputs change 1ns after the
// rising edge. Outputs are sampled at least 1ns after the rising edge.
// Ports: none (top-level bench).
module tb_stv_fifo;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // instance a: DEPTH=4, FLOW=0
  logic       a_clear = 0, a_dv = 0, a_dr = 0, a_drdy, a_ov, a_empty, a_full, a_af;
  logic [7:0] a_din = 0, a_dout;
  logic [2:0] a_count;
  // instance b: DEPTH=4, FLOW=1
  logic       b_clear = 0, b_dv = 0, b_dr = 0, b_drdy, b_ov, b_empty, b_full, b_af;
  logic [7:0] b_din = 0, b_dout;
  logic [2:0] b_count;
  // instance c: DEPTH=3, FLOW=0
  logic       c_clear = 0, c_dv = 0, c_dr = 0, c_drdy, c_ov, c_empty, c_full, c_af;
  logic [7:0] c_din = 0, c_dout;
  logic [1:0] c_count;

  stv_fifo #(.DEPTH(4), .FLOW(1'b0)) u_a (
    .clk(clk), .arst(arst), .clear(a_clear), .din_valid(a_dv), .din_ready(a_drdy),
    .din(a_din), .dout_valid(a_ov), .dout_ready(a_dr), .dout(a_dout), .count(a_count),
    .empty(a_empty), .full(a_full), .almost_full(a_af));

  stv_fifo #(.DEPTH(4), .FLOW(1'b1)) u_b (
    .clk(clk), .arst(arst), .clear(b_clear), .din_valid(b_dv), .din_ready(b_drdy),
    .din(b_din), .dout_valid(b_ov), .dout_ready(b_dr), .dout(b_dout), .count(b_count),
    .empty(b_empty), .full(b_full), .almost_full(b_af));

  stv_fifo #(.DEPTH(3), .FLOW(1'b0)) u_c (
    .clk(clk), .arst(arst), .clear(c_clear), .din_valid(c_dv), .din_ready(c_drdy),
    .din(c_din), .dout_valid(c_ov), .dout_ready(c_dr), .dout(c_dout), .count(c_count),
    .empty(c_empty), .full(c_full), .almost_full(c_af));

  // stimulus only: one accepted beat into instance a, no pop
  task automatic push_a(input logic [7:0] v);
    a_din = v; a_dv = 1'b1;
    @(posedge clk); #1;
    a_dv = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vecs++; if (a_drdy !== 1'b1)  begin errs++; $display("FAIL reset_din_ready: got %b exp 1", a_drdy); end
    vecs++; if (a_ov !== 1'b0)    begin errs++; $display("FAIL reset_dout_valid: got %b exp 0", a_ov); end
    vecs++; if (a_count !== 3'd0) begin errs++; $display("FAIL reset_count: got %0d exp 0", a_count); end
    vecs++; if (a_empty !== 1'b1) begin errs++; $display("FAIL reset_empty: got %b exp 1", a_empty); end
    vecs++; if (a_full !== 1'b0)  begin errs++; $display("FAIL reset_full: got %b exp 0", a_full); end
    vecs++; if (a_af !== 1'b0)    begin errs++; $display("FAIL reset_almost_full: got %b exp 0", a_af); end
    b_din = 8'h5A; b_dv = 1'b1; #1;
    vecs++; if (b_ov !== 1'b1)     begin errs++; $display("FAIL reset_flow_valid: got %b exp 1", b_ov); end
    vecs++; if (b_dout !== 8'h5A)  begin errs++; $display("FAIL reset_flow_dout: got %h exp 5a", b_dout); end
    b_dv = 1'b0; #1;
    vecs++; if (b_ov !== 1'b0)     begin errs++; $display("FAIL reset_flow_novalid: got %b exp 0", b_ov); end
    @(negedge clk); arst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain();
    logic [7:0] e;
    a_dr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_a(8'(8'h11 * (i + 1)));
      vecs++; if (a_count !== 3'(i + 1)) begin errs++; $display("FAIL fill_count[%0d]: got %0d exp %0d", i, a_count, i + 1); end
      vecs++; if (a_af !== (i >= 2))     begin errs++; $display("FAIL fill_almost_full[%0d]: got %b exp %b", i, a_af, (i >= 2)); end
      vecs++; if (a_full !== (i == 3))   begin errs++; $display("FAIL fill_full[%0d]: got %b exp %b", i, a_full, (i == 3)); end
      vecs++; if (a_drdy !== (i != 3))   begin errs++; $display("FAIL fill_din_ready[%0d]: got %b exp %b", i, a_drdy, (i != 3)); end
    end
    a_dr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = 8'(8'h11 * (i + 1));
      #1;
      vecs++; if (a_ov !== 1'b1) begin errs++; $display("FAIL drain_valid[%0d]: got %b exp 1", i, a_ov); end
      vecs++; if (a_dout !== e)  begin errs++; $display("FAIL drain_dout[%0d]: got %h exp %h", i, a_dout, e); end
      @(posedge clk); #1;
    end
    a_dr = 1'b0;
    vecs++; if (a_empty !== 1'b1) begin errs++; $display("FAIL drain_empty: got %b exp 1", a_empty); end
    vecs++; if (a_ov !== 1'b0)    begin errs++; $display("FAIL drain_novalid: got %b exp 0", a_ov); end
  endtask

  task automatic test_steady_stream();
    logic [7:0] e;
    push_a(8'h50);
    push_a(8'h51);
    for (int i = 0; i < 8; i++) begin
      a_din = 8'(8'h52 + i); a_dv = 1'b1; a_dr = 1'b1;
      e = 8'(8'h50 + i);
      #1;
      vecs++; if (a_dout !== e) begin errs++; $display("FAIL stream_dout[%0d]: got %h exp %h", i, a_dout, e); end
      @(posedge clk); #1;
      vecs++; if (a_count !== 3'd2) begin errs++; $display("FAIL stream_count[%0d]: got %0d exp 2", i, a_count); end
    end
    a_dv = 1'b0;
    for (int k = 0; k < 2; k++) begin
      e = 8'(8'h58 + k);
      #1;
      vecs++; if (a_dout !== e) begin errs++; $display("FAIL stream_tail[%0d]: got %h exp %h", k, a_dout, e); end
      @(posedge clk); #1;
    end
    a_dr = 1'b0;
    vecs++; if (a_empty !== 1'b1) begin errs++; $display("FAIL stream_empty: got %b exp 1", a_empty); end
  endtask

  task automatic test_bypass();
    b_din = 8'hA5; b_dv = 1'b1; b_dr = 1'b1; #1;
    vecs++; if (b_ov !== 1'b1)    begin errs++; $display("FAIL bypass_valid: got %b exp 1", b_ov); end
    vecs++; if (b_dout !== 8'hA5) begin errs++; $display("FAIL bypass_dout: got %h exp a5", b_dout); end
    @(posedge clk); #1;
    vecs++; if (b_count !== 3'd0) begin errs++; $display("FAIL bypass_count: got %0d exp 0", b_count); end
    b_dr = 1'b0; #1;
    vecs++; if (b_dout !== 8'hA5) begin errs++; $display("FAIL bypass_hold_dout: got %h exp a5", b_dout); end
    @(posedge clk); #1;
    b_din = 8'h3C; #1;
    vecs++; if (b_count !== 3'd1) begin errs++; $display("FAIL bypass_stored_count: got %0d exp 1", b_count); end
    vecs++; if (b_dout !== 8'hA5) begin errs++; $display("FAIL bypass_stored_dout: got %h exp a5", b_dout); end
    vecs++; if (b_ov !== 1'b1)    begin errs++; $display("FAIL bypass_stored_valid: got %b exp 1", b_ov); end
    @(posedge clk); #1;
    b_dv = 1'b0; b_dr = 1'b1; #1;
    vecs++; if (b_dout !== 8'hA5) begin errs++; $display("FAIL bypass_drain0: got %h exp a5", b_dout); end
    @(posedge clk); #1;
    vecs++; if (b_dout !== 8'h3C) begin errs++; $display("FAIL bypass_drain1: got %h exp 3c", b_dout); end
    @(posedge clk); #1;
    b_dr = 1'b0;
    vecs++; if (b_empty !== 1'b1) begin errs++; $display("FAIL bypass_empty: got %b exp 1", b_empty); end
  endtask

  task automatic test_wrap();
    int sent = 0, recv = 0, wr_wraps = 0, rd_wraps = 0, cyc = 0;
    bit hold = 1'b0, push, pop;
    logic [1:0] wp, rp;
    while (recv < 10 && cyc < 400) begin
      if (!hold) begin
        c_dv = (sent < 10) && ($urandom_range(0, 3) != 0);
        c_din = 8'(sent);
      end
      c_dr = ($urandom_range(0, 2) != 0);
      #1;
      push = c_dv && c_drdy;
      pop  = c_ov && c_dr;
      if (pop) begin
        vecs++; if (c_dout !== 8'(recv)) begin errs++; $display("FAIL wrap_dout[%0d]: got %h exp %h", recv, c_dout, 8'(recv)); end
        recv++;
      end
      hold = c_dv && !c_drdy;
      wp = u_c.wr_ptr; rp = u_c.rd_ptr;
      @(posedge clk); #1;
      if (push) sent++;
      if (wp == 2'd2 && u_c.wr_ptr == 2'd0) wr_wraps++;
      if (rp == 2'd2 && u_c.rd_ptr == 2'd0) rd_wraps++;
      cyc++;
    end
    c_dv = 1'b0; c_dr = 1'b0;
    vecs++; if (recv != 10)    begin errs++; $display("FAIL wrap_beats: got %0d exp 10", recv); end
    vecs++; if (wr_wraps < 3)  begin errs++; $display("FAIL wrap_wr_ptr: got %0d exp >=3", wr_wraps); end
    vecs++; if (rd_wraps < 3)  begin errs++; $display("FAIL wrap_rd_ptr: got %0d exp >=3", rd_wraps); end
  endtask

  task automatic test_clear();
    push_a(8'h61); push_a(8'h62); push_a(8'h63);
    a_clear = 1'b1; a_dv = 1'b1; a_din = 8'h77; a_dr = 1'b1; #1;
    vecs++; if (a_drdy !== 1'b0) begin errs++; $display("FAIL clear_din_ready: got %b exp 0", a_drdy); end
    vecs++; if (a_ov !== 1'b0)   begin errs++; $display("FAIL clear_dout_valid: got %b exp 0", a_ov); end
    @(posedge clk); #1;
    a_clear = 1'b0; #1;
    vecs++; if (a_count !== 3'd0) begin errs++; $display("FAIL clear_count: got %0d exp 0", a_count); end
    vecs++; if (a_empty !== 1'b1) begin errs++; $display("FAIL clear_empty: got %b exp 1", a_empty); end
    vecs++; if (a_ov !== 1'b0)    begin errs++; $display("FAIL clear_novalid: got %b exp 0", a_ov); end
    @(posedge clk); #1;
    a_dv = 1'b0; #1;
    vecs++; if (a_dout !== 8'h77) begin errs++; $display("FAIL clear_first_out: got %h exp 77", a_dout); end
    vecs++; if (a_ov !== 1'b1)    begin errs++; $display("FAIL clear_first_valid: got %b exp 1", a_ov); end
    @(posedge clk); #1;
    a_dr = 1'b0;
    vecs++; if (a_empty !== 1'b1) begin errs++; $display("FAIL clear_drained: got %b exp 1", a_empty); end
  endtask

  task automatic test_arst_mid();
    push_a(8'h91); push_a(8'h92);
    #3 arst = 1'b1;
    #1;
    vecs++; if (a_count !== 3'd0) begin errs++; $display("FAIL arst_count: got %0d exp 0", a_count); end
    vecs++; if (a_empty !== 1'b1) begin errs++; $display("FAIL arst_empty: got %b exp 1", a_empty); end
    vecs++; if (a_ov !== 1'b0)    begin errs++; $display("FAIL arst_dout_valid: got %b exp 0", a_ov); end
    vecs++; if (a_drdy !== 1'b1)  begin errs++; $display("FAIL arst_din_ready: got %b exp 1", a_drdy); end
    @(negedge clk); arst = 1'b0;
    @(posedge clk); #1;
    push_a(8'hA1); push_a(8'hA2);
    a_dr = 1'b1; #1;
    vecs++; if (a_dout !== 8'hA1) begin errs++; $display("FAIL arst_first_out: got %h exp a1", a_dout); end
    @(posedge clk); #1;
    vecs++; if (a_dout !== 8'hA2) begin errs++; $display("FAIL arst_second_out: got %h exp a2", a_dout); end
    @(posedge clk); #1;
    a_dr = 1'b0;
    vecs++; if (a_empty !== 1'b1) begin errs++; $display("FAIL arst_drained: got %b exp 1", a_empty); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_steady_stream();
    test_bypass();
    test_wrap();
    test_clear();
    test_arst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
